// File: rtl/reg_bank_loader_pkg.sv
// Shared types and constants for the 74HCT173 bank write sequencer.
package reg_bank_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int CLR_CYCLES = 2;

   localparam logic [1:0] EN_LOAD = 2'b00;
   localparam logic [1:0] EN_HOLD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOAD  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_CLR   = 3'd4
   } state_t;

endpackage

// File: rtl/reg_bank_loader_nibble_fifo.sv
// Synchronous FIFO of {addr, data} write entries; full/empty derive from the registered count.
module nibble_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic                     CP,
   input  logic                     MR,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   always_ff @(posedge CP) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reg_bank_loader.sv
// Replays buffered nibble writes onto a 74HCT173 bank with setup/load/hold framing,
// and sequences a bank-wide clear on request.
//
//   state | meaning
//   IDLE  | waiting; clear has priority, else pop FIFO head and latch addr/data
//   SETUP | D driven with latched data, all enables high
//   LOAD  | enable pair of latched register low for this cycle only
//   HOLD  | D still held, enables high, done (and err if addr out of range)
//   CLR   | bank_mr high for CLR_CYCLES cycles, done in the last one
module reg_bank_loader
   import reg_bank_pkg::*;
#(
   parameter  int NREG  = 4,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                  CP,
   input  logic                  MR,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [AW-1:0]         wr_addr,
   input  logic [NIBBLE_W-1:0]   wr_data,
   input  logic                  clr_req,
   output logic [NIBBLE_W-1:0]   D,
   output logic [2*NREG-1:0]     E_n,
   output logic                  bank_mr,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int FW  = AW + NIBBLE_W;
   localparam int CCW = $clog2(CLR_CYCLES + 1);
   localparam logic [AW:0]       NREG_V   = (AW+1)'(NREG);
   localparam logic [2*NREG-1:0] EN_IDLE  = {NREG{EN_HOLD}};

   state_t                 state;
   logic [AW-1:0]          lat_addr;
   logic                   clr_pend;
   logic [CCW-1:0]         clr_cnt;

   logic [FW-1:0]          fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   push;
   logic                   pop;
   logic                   addr_ok;
   logic [2*NREG-1:0]      en_load;

   assign wr_ready = !fifo_full;
   assign push     = wr_valid && !fifo_full;
   assign pop      = (state == ST_IDLE) && !clr_pend && !fifo_empty;
   assign addr_ok  = ({1'b0, lat_addr} < NREG_V);
   assign busy     = (state != ST_IDLE) || (fifo_count != '0) || clr_pend;

   nibble_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CP    (CP),
      .MR    (MR),
      .push  (push),
      .pop   (pop),
      .din   ({wr_addr, wr_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Out-of-range addresses match no pair, so the bank never sees a load for them.
   always_comb begin
      en_load = EN_IDLE;
      for (int i = 0; i < NREG; i++) begin
         if (addr_ok && (lat_addr == AW'(i))) begin
            en_load[2*i +: 2] = EN_LOAD;
         end
      end
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         state    <= ST_IDLE;
         lat_addr <= '0;
         clr_pend <= 1'b0;
         clr_cnt  <= '0;
         D        <= '0;
         E_n      <= EN_IDLE;
         bank_mr  <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         E_n     <= EN_IDLE;
         bank_mr <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         if (clr_req) begin
            clr_pend <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               // Entering CLR wins over a coincident clr_req: that pulse is absorbed.
               if (clr_pend) begin
                  state    <= ST_CLR;
                  clr_pend <= 1'b0;
                  bank_mr  <= 1'b1;
                  clr_cnt  <= CCW'(CLR_CYCLES - 1);
               end else if (!fifo_empty) begin
                  {lat_addr, D} <= fifo_dout;
                  state         <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               E_n   <= en_load;
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               done  <= 1'b1;
               err   <= !addr_ok;
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               state <= ST_IDLE;
            end
            ST_CLR: begin
               if (clr_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  bank_mr <= 1'b1;
                  clr_cnt <= clr_cnt - 1'b1;
                  if (clr_cnt == CCW'(1)) begin
                     done <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
